// File: rtl/from_layer_to_uart_pkg.sv
// Shared constants, FSM encoding and helpers for the image-to-UART
// reporter.
package from_layer_to_uart_pkg;

  localparam int IMG_ROWS = 28;
  localparam int IMG_COLS = 28;
  localparam int IMG_BITS = 784;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_1   = 8'h31;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_ERR = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_FINISH
  } state_e;

  function automatic logic [7:0] result_char(input logic [3:0] d);
    return (d <= 4'd9) ? (ASCII_0 + {4'd0, d}) : ASCII_ERR;
  endfunction

endpackage

// File: rtl/from_layer_to_uart_tx.sv
// 8N1 byte serialiser: holds each bit for CLKS_PER_BIT cycles,
// line idles high.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_line,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic          active_q, active_d;
  logic [9:0]    sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    active_d = active_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    if (!active_q) begin
      if (tx_start) begin
        active_d = 1'b1;
        sh_d     = {1'b1, tx_data, 1'b0};
        cnt_d    = '0;
        bit_d    = '0;
      end
    end else if (bit_end) begin
      cnt_d = '0;
      if (bit_q == 4'd9) begin
        active_d = 1'b0;
      end else begin
        bit_d = bit_q + 4'd1;
        sh_d  = {1'b1, sh_q[9:1]};
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      sh_q     <= '1;
      cnt_q    <= '0;
      bit_q    <= '0;
    end else begin
      active_q <= active_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
    end
  end

  // Done marks the last cycle of the stop bit so the next byte can
  // be issued with a single idle cycle in between.
  assign tx_line = active_q ? sh_q[0] : 1'b1;
  assign tx_busy = active_q;
  assign tx_done = active_q && bit_end && (bit_q == 4'd9);

endmodule

// File: rtl/from_layer_to_uart.sv
// Streams a latched 28x28 binary image as ASCII rows followed by the
// classification digit over a UART line.
module from_layer_to_uart
  import from_layer_to_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IMG_BITS-1:0] x,
  input  logic [3:0]          digit,
  output logic                uart_tx,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  logic [IMG_BITS-1:0] x_q;
  logic [3:0]          digit_q;
  logic [4:0]          pix_q, pix_d;
  logic [4:0]          row_q, row_d;
  logic [4:0]          cur_pix, cur_row;
  logic [9:0]          idx;
  logic                last_byte;
  logic                tx_start, tx_line, tx_busy, tx_done;
  logic [7:0]          tx_data;

  // The first byte leaves from LOAD, before the cleared counters are
  // visible, so the byte selector sees zero there.
  assign cur_row = (state_q == S_LOAD) ? 5'd0 : row_q;
  assign cur_pix = (state_q == S_LOAD) ? 5'd0 : pix_q;

  assign idx = 10'(IMG_BITS - 1 - int'(cur_row) * IMG_COLS
                 - int'(cur_pix));

  always_comb begin
    if (cur_row == 5'(IMG_ROWS)) begin
      tx_data = (cur_pix == 5'd0) ? result_char(digit_q) : ASCII_LF;
    end else if (cur_pix == 5'(IMG_COLS)) begin
      tx_data = ASCII_LF;
    end else begin
      tx_data = x_q[idx] ? ASCII_1 : ASCII_0;
    end
  end

  assign last_byte = (row_q == 5'(IMG_ROWS)) && (pix_q == 5'd1);

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    row_d    = row_q;
    tx_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        pix_d    = '0;
        row_d    = '0;
        tx_start = 1'b1;
        state_d  = S_WAIT;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          if (last_byte) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_SEND;
            if (row_q == 5'(IMG_ROWS)) begin
              pix_d = pix_q + 5'd1;
            end else if (pix_q == 5'(IMG_COLS)) begin
              pix_d = '0;
              row_d = row_q + 5'd1;
            end else begin
              pix_d = pix_q + 5'd1;
            end
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      digit_q <= '0;
      pix_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      row_q   <= row_d;
      if (state_q == S_IDLE && start) begin
        x_q     <= x;
        digit_q <= digit;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_line (tx_line),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  assign uart_tx = tx_line;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FINISH);

endmodule

// File: tb/tb_from_layer_to_uart.sv
// Bench for from_layer_to_uart: a 4-clk/bit instance for the reference
// transfer and a 1-clk/bit instance for the remaining scenarios.
module tb_from_layer_to_uart;

  localparam int CPB_A  = 4;
  localparam int CPB_B  = 1;
  localparam int NBYTES = 814;
  localparam int LIMIT  = 40000;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [783:0] xv;
    logic [3:0]   dv;
    logic [7:0]   b0;
    logic [7:0]   b1;
    logic [7:0]   res;
    int           pre;
    string        name;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_a, rst_b;
  logic         start_a, start_b;
  logic [783:0] x_a, x_b;
  logic [3:0]   digit_a, digit_b;
  logic         tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  int  n_cmp = 0;
  int  n_bad = 0;
  bq_t rxa, rxb;
  int  ep_a = 0, ep_b = 0;
  int  fe_a = 0, fe_b = 0;

  always #5 clk = ~clk;

  from_layer_to_uart #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .x(x_a),
    .digit(digit_a), .uart_tx(tx_a), .busy(busy_a), .done(done_a)
  );

  from_layer_to_uart #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .x(x_b),
    .digit(digit_b), .uart_tx(tx_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, need %0h", nm, act, exp);
    end
  endtask

  function automatic logic line_of(input int w);
    return (w == 0) ? tx_a : tx_b;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 0) ? done_a : done_b;
  endfunction
  function automatic int rx_size(input int w);
    return (w == 0) ? rxa.size() : rxb.size();
  endfunction
  function automatic int ep_of(input int w);
    return (w == 0) ? ep_a : ep_b;
  endfunction

  task automatic drive(input int w, input logic s, input logic [783:0] xv,
                       input logic [3:0] dv);
    if (w == 0) begin start_a = s; x_a = xv; digit_a = dv; end
    else begin start_b = s; x_b = xv; digit_b = dv; end
  endtask

  task automatic set_start(input int w, input logic s);
    if (w == 0) start_a = s;
    else start_b = s;
  endtask

  task automatic clr_rx(input int w);
    if (w == 0) rxa.delete();
    else rxb.delete();
  endtask

  // Mid-bit sampling receiver; frames cut by a reset are discarded.
  task automatic rx_loop(input int w);
    int cpb, ep;
    logic [7:0] b;
    logic stp;
    cpb = (w == 0) ? CPB_A : CPB_B;
    forever begin
      @(negedge clk);
      if (line_of(w) === 1'b0) begin
        ep = ep_of(w);
        repeat (cpb / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (cpb) @(negedge clk);
          b[i] = line_of(w);
        end
        repeat (cpb) @(negedge clk);
        stp = line_of(w);
        if (ep == ep_of(w)) begin
          if (w == 0) rxa.push_back(b);
          else rxb.push_back(b);
          if (stp !== 1'b1) begin
            if (w == 0) fe_a++;
            else fe_b++;
          end
        end
      end
    end
  endtask

  function automatic bq_t model(input logic [783:0] xv,
                                input logic [7:0] res);
    bq_t q;
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++)
        q.push_back(xv[783 - 28 * r - c] ? 8'h31 : 8'h30);
      q.push_back(8'h0A);
    end
    q.push_back(res);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic cmp_stream(input string nm, input bq_t got,
                            input bq_t exp);
    int bad, n;
    bad = 0;
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    check({nm, ".len"}, got.size(), exp.size());
    for (int i = 0; i < n; i++)
      if (got[i] !== exp[i]) bad++;
    check({nm, ".bytes_wrong"}, bad, 0);
  endtask

  task automatic xfer(input int w, input logic [783:0] xv,
                      input logic [3:0] dv, input bit glitch,
                      output int lat, output int dur, output int nd,
                      output int dcyc, output int cyc, output bit ovf);
    bit pend, pulse;
    lat = -1; dur = 0; nd = 0; dcyc = -1; cyc = 0;
    pend = glitch; pulse = 0;
    clr_rx(w);
    @(negedge clk);
    drive(w, 1'b1, xv, dv);
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        set_start(w, 1'b0);
        if (glitch) drive(w, 1'b0, '1, 4'hF);
      end else if (pulse) begin
        set_start(w, 1'b0);
        pulse = 0;
      end else if (pend && rx_size(w) >= 100) begin
        set_start(w, 1'b1);
        pend = 0;
        pulse = 1;
      end
      if (busy_of(w) === 1'b1) dur++;
      if (done_of(w) === 1'b1) begin nd++; dcyc = cyc; end
      if (lat < 0 && line_of(w) === 1'b0) lat = cyc;
    end while (busy_of(w) === 1'b1 && cyc < LIMIT);
    ovf = (cyc >= LIMIT);
  endtask

  task automatic check_xfer(input string nm, input int w, input int lat,
                            input int dur, input int nd, input int dcyc,
                            input int cyc, input bit ovf);
    int cpb;
    cpb = (w == 0) ? CPB_A : CPB_B;
    check({nm, ".timeout"}, ovf, 0);
    check({nm, ".first_start_le2"}, (lat >= 1 && lat <= 2), 1);
    check({nm, ".done_count"}, nd, 1);
    check({nm, ".busy_falls_after_done"}, cyc, dcyc + 1);
    check({nm, ".duration_in_range"},
          (dur >= NBYTES * 10 * cpb && dur <= NBYTES * (10 * cpb + 2) + 4),
          1);
  endtask

  task automatic run_a();
    int lat, dur, nd, dcyc, cyc;
    bit ovf;
    bq_t q;
    xfer(0, '0, 4'd7, 1'b0, lat, dur, nd, dcyc, cyc, ovf);
    check_xfer("a_zero_d7", 0, lat, dur, nd, dcyc, cyc, ovf);
    q = rxa;
    cmp_stream("a_zero_d7", q, model('0, 8'h37));
    check("a_zero_d7.byte0", q[0], 8'h30);
    check("a_zero_d7.row_lf", q[28], 8'h0A);
    check("a_zero_d7.result", q[812], 8'h37);
    check("a_zero_d7.framing", fe_a, 0);
  endtask

  task automatic rst_mid_b();
    int cyc;
    drive(1, 1'b0, {392{2'b10}}, 4'd3);
    @(negedge clk);
    clr_rx(1);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0;
    while (rxb.size() < 400 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check("rst.reached_byte400", rxb.size() >= 400, 1);
    cyc = 0;
    while (tx_b !== 1'b0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst.line_low_before", tx_b, 1'b0);
    #2;
    rst_b = 1'b0;
    ep_b++;
    #1;
    check("rst.async_uart_tx", tx_b, 1'b1);
    check("rst.async_busy", busy_b, 1'b0);
    check("rst.async_done", done_b, 1'b0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic run_b();
    vec_t tbl[4];
    int lat, dur, nd, dcyc, cyc, nbusy;
    bit ovf;
    bq_t q;
    logic [783:0] corner;
    corner = '0;
    corner[783] = 1'b1;
    corner[0] = 1'b1;
    tbl[0] = '{{392{2'b10}}, 4'd0, 8'h31, 8'h30, 8'h30, 0, "alt_d0"};
    tbl[1] = '{'0, 4'd12, 8'h30, 8'h30, 8'h3F, 1, "b2b_zero_d12"};
    tbl[2] = '{'1, 4'd9, 8'h31, 8'h31, 8'h39, 2, "post_rst_ones_d9"};
    tbl[3] = '{corner, 4'd4, 8'h31, 8'h30, 8'h34, 3, "glitch_corner_d4"};
    for (int i = 0; i < 4; i++) begin
      if (tbl[i].pre == 2) rst_mid_b();
      else if (tbl[i].pre != 1) repeat (5) @(negedge clk);
      xfer(1, tbl[i].xv, tbl[i].dv, tbl[i].pre == 3,
           lat, dur, nd, dcyc, cyc, ovf);
      check_xfer(tbl[i].name, 1, lat, dur, nd, dcyc, cyc, ovf);
      q = rxb;
      cmp_stream(tbl[i].name, q, model(tbl[i].xv, tbl[i].res));
      check({tbl[i].name, ".byte0"}, q[0], tbl[i].b0);
      check({tbl[i].name, ".byte1"}, q[1], tbl[i].b1);
      check({tbl[i].name, ".result"}, q[812], tbl[i].res);
      check({tbl[i].name, ".trailer"}, q[813], 8'h0A);
      if (tbl[i].pre == 3) begin
        nbusy = 0;
        repeat (30) begin
          @(negedge clk);
          if (busy_b !== 1'b0) nbusy++;
        end
        check("glitch.no_queued_start", nbusy, 0);
      end
    end
    check("b.framing", fe_b, 0);
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(0, 1'b0, '0, 4'd0);
    drive(1, 1'b0, '0, 4'd0);
    #1;
    check("reset.a_uart_tx", tx_a, 1'b1);
    check("reset.a_busy", busy_a, 1'b0);
    check("reset.a_done", done_a, 1'b0);
    check("reset.b_uart_tx", tx_b, 1'b1);
    check("reset.b_busy", busy_b, 1'b0);
    check("reset.b_done", done_b, 1'b0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    fork
      rx_loop(0);
      rx_loop(1);
    join_none
    repeat (3) @(negedge clk);
    fork
      run_a();
      run_b();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
